// File: rtl/factory_alloc_arbiter.sv
// Round-robin object-handle allocator: grants one requester per cycle from a circular
// free list, tracks allocated handles and records the requested type per handle.
module factory_alloc_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned NUM_HANDLES = 16,
  parameter int unsigned TYPE_W      = 8,
  localparam int unsigned HW = $clog2(NUM_HANDLES),
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TYPE_W-1:0] req_type,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [IW-1:0]             rsp_id,
  output logic [HW-1:0]             rsp_handle,
  output logic [TYPE_W-1:0]         rsp_type,
  input  logic                      rel_valid,
  input  logic [HW-1:0]             rel_handle,
  output logic                      rel_err,
  output logic [HW:0]               free_count,
  output logic                      empty
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [HW-1:0]         head;
  logic [HW-1:0]         tail;
  logic [HW-1:0]         init_cnt;
  logic [NUM_HANDLES-1:0] alloc;
  logic [IW-1:0]         last_grant;
  logic [HW-1:0]         free_list [NUM_HANDLES];
  logic [TYPE_W-1:0]     type_tab  [NUM_HANDLES];

  logic [NUM_REQ-1:0]    grant_c;
  logic                  grant_any;
  logic [IW-1:0]         grant_idx;
  logic [31:0]           search_idx;
  logic [TYPE_W-1:0]     grant_type;
  logic [HW-1:0]         head_handle;
  logic                  rel_legal;
  logic [HW:0]           free_count_nxt;

  // Round-robin search starting just above the last grantee; only when a handle is free.
  always_comb begin
    grant_c    = '0;
    grant_any  = 1'b0;
    grant_idx  = last_grant;
    search_idx = '0;
    if (state == RUN && free_count != '0) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        search_idx = (32'(last_grant) + k) % NUM_REQ;
        if (!grant_any && req_valid[search_idx]) begin
          grant_any = 1'b1;
          grant_idx = IW'(search_idx);
        end
      end
    end
    if (grant_any) grant_c[grant_idx] = 1'b1;
  end

  assign req_ready   = grant_c;
  assign grant_type  = req_type[32'(grant_idx)*TYPE_W +: TYPE_W];
  assign head_handle = free_list[head];
  // The handle being granted still has its allocated bit clear, so releasing it is illegal.
  assign rel_legal   = rel_valid && (state == RUN) && alloc[rel_handle];
  assign rsp_type    = type_tab[rsp_handle];

  always_comb begin
    free_count_nxt = free_count;
    if (state == INIT)                free_count_nxt = free_count + (HW+1)'(1);
    else if (grant_any && !rel_legal) free_count_nxt = free_count - (HW+1)'(1);
    else if (!grant_any && rel_legal) free_count_nxt = free_count + (HW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      init_cnt   <= '0;
      alloc      <= '0;
      last_grant <= IW'(NUM_REQ-1);
      free_count <= '0;
      empty      <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_handle <= '0;
      rel_err    <= 1'b0;
      for (int unsigned i = 0; i < NUM_HANDLES; i++) type_tab[i] <= '0;
    end else begin
      free_count <= free_count_nxt;
      empty      <= (free_count_nxt == '0);
      rsp_valid  <= grant_any;
      rel_err    <= rel_valid && !rel_legal;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + HW'(1);
          if (init_cnt == HW'(NUM_HANDLES-1)) state <= RUN;
        end
        RUN: begin
          if (grant_any) begin
            head                  <= head + HW'(1);
            alloc[head_handle]    <= 1'b1;
            type_tab[head_handle] <= grant_type;
            last_grant            <= grant_idx;
            rsp_id                <= grant_idx;
            rsp_handle            <= head_handle;
          end
          if (rel_legal) begin
            tail              <= tail + HW'(1);
            alloc[rel_handle] <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Free-list storage needs no reset: INIT rewrites every slot.
  always_ff @(posedge clk) begin
    if (state == INIT)  free_list[init_cnt] <= init_cnt;
    else if (rel_legal) free_list[tail]     <= rel_handle;
  end

endmodule

// File: tb/tb_factory_alloc_arbiter.sv
// Randomized bench for factory_alloc_arbiter: queue-based free-list model, scoreboard on rsp.
module tb_factory_alloc_arbiter;

  localparam int NR = 4;
  localparam int NH = 16;
  localparam int TW = 8;

  logic            clk, rst;
  logic [NR-1:0]   req_valid;
  logic [NR*TW-1:0] req_type;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [3:0]      rsp_handle;
  logic [TW-1:0]   rsp_type;
  logic            rel_valid;
  logic [3:0]      rel_handle;
  logic            rel_err;
  logic [4:0]      free_count;
  logic            empty;

  factory_alloc_arbiter #(.NUM_REQ(NR), .NUM_HANDLES(NH), .TYPE_W(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_handle(rsp_handle), .rsp_type(rsp_type),
    .rel_valid(rel_valid), .rel_handle(rel_handle), .rel_err(rel_err),
    .free_count(free_count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; int h; int t; } rsp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];
  int   fq[$];
  bit   m_alloc [NH];
  bit   m_init;
  int   m_k;
  int   m_last;
  bit   exp_rsp_valid, exp_rel_err;
  bit   pend [NR];
  logic [TW-1:0] ptype [NR];
  int   last_rel;
  bit   did_reset;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    foreach (m_alloc[i]) m_alloc[i] = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
    m_init = 1'b1;
    m_k = 0;
    m_last = NR - 1;
    exp_rsp_valid = 1'b0;
    exp_rel_err = 1'b0;
    last_rel = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_handle", int'(rsp_handle), 0);
    check("rst_rsp_type", int'(rsp_type), 0);
    check("rst_rel_err", int'(rel_err), 0);
    check("rst_free_count", int'(free_count), 0);
    check("rst_empty", int'(empty), 1);
  endtask

  task automatic check_regs();
    check("rsp_valid", int'(rsp_valid), int'(exp_rsp_valid));
    check("rel_err", int'(rel_err), int'(exp_rel_err));
    check("free_count", int'(free_count), fq.size());
    check("empty", int'(empty), int'(fq.size() == 0));
  endtask

  // Drive one cycle of stimulus, predict the grant, then advance the model past the next edge.
  task automatic drive_and_step(input int cyc);
    int rel_pct, g, h, r;
    int al[$];
    bit legal;
    rel_pct = m_init ? 5 : ((cyc % 250) < 70 ? 0 : 45);
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < 60) begin
        pend[i] = 1'b1;
        ptype[i] = TW'($urandom);
      end
      req_valid[i] = pend[i];
      req_type[i*TW +: TW] = ptype[i];
    end
    rel_valid = 1'b0;
    rel_handle = 4'($urandom_range(0, NH-1));
    if ($urandom_range(0, 99) < rel_pct) begin
      for (int i = 0; i < NH; i++) if (m_alloc[i]) al.push_back(i);
      r = $urandom_range(0, 9);
      rel_valid = 1'b1;
      if (r < 7 && al.size() > 0) rel_handle = 4'(al[$urandom_range(0, al.size()-1)]);
      else if (r < 8) rel_handle = 4'(last_rel);
    end
    #1;
    g = -1;
    if (!m_init && fq.size() > 0)
      for (int k = 1; k <= NR; k++)
        if (g < 0 && pend[(m_last + k) % NR]) g = (m_last + k) % NR;
    check("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
    legal = !m_init && rel_valid && m_alloc[rel_handle];
    exp_rsp_valid = (g >= 0);
    exp_rel_err = rel_valid && !legal;
    if (m_init) begin
      fq.push_back(m_k);
      m_k++;
      if (m_k == NH) m_init = 1'b0;
    end else begin
      if (g >= 0) begin
        h = fq.pop_front();
        m_alloc[h] = 1'b1;
        exp_q.push_back('{g, h, int'(ptype[g])});
        pend[g] = 1'b0;
        m_last = g;
      end
      if (legal) begin
        m_alloc[rel_handle] = 1'b0;
        fq.push_back(int'(rel_handle));
        last_rel = int'(rel_handle);
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rel_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    check("rsp_queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: every response strobe must match the oldest predicted grant.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d handle=%0d, expected no response", rsp_id, rsp_handle);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check("rsp_handle", int'(rsp_handle), e.h);
        check("rsp_type", int'(rsp_type), e.t);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_type = '0;
    rel_valid = 1'b0;
    rel_handle = '0;
    did_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    drive_and_step(0);
    for (int cyc = 1; cyc < 1200; cyc++) begin
      @(posedge clk);
      #1;
      check_regs();
      if (!did_reset && !m_init && cyc > 150 && ((NH - fq.size()) == 7 || cyc == 700)) begin
        did_reset = 1'b1;
        do_reset();
      end
      drive_and_step(cyc);
    end
    @(posedge clk);
    #1;
    check_regs();
    req_valid = '0;
    rel_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rsp_queue_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
